fib_bram_seq: RTL and testbench
===============================

# fib_bram_seq

Parametrised sequencer that fills a dual-port block RAM with the Fibonacci sequence through port A, then reads it back through port B and checks every word. It replaces the fixed six-step BRAM driver with a start/busy/done handshake, configurable data width, address width, word count and base address, plus self-check error reporting. It sits between the top-level control and the dual-port BRAM instance. All outputs are registered on the rising edge of clk.

## Interface
- DATA_W, 48, data width of both BRAM ports
- ADDR_W, 10, address width of both BRAM ports
- COUNT, 16, number of Fibonacci words written; legal range 2..2^ADDR_W
- BASE_ADDR, 0, first write/read address
- clk  in  1  system clock, rising edge
- reset  in  1  reset reset, asynchronous, active-low; clock clk
- start  in  1  start request, sampled on rising edge
- busy  out  1  high while a run is in progress
- done  out  1  high after run completion until the next start or reset
- err  out  1  sticky mismatch flag for the current run
- err_addr  out  ADDR_W  address of the first mismatch
- data_a  out  DATA_W  port A write data
- addr_a  out  ADDR_W  port A address
- we_a  out  1  port A write enable
- data_b  out  DATA_W  port B write data, constant 0
- addr_b  out  ADDR_W  port B address
- we_b  out  1  port B write enable, constant 0
- q_b  in  DATA_W  port B read data, valid one clock after addr_b is registered

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE: start=1 clears done, err and err_addr, resets index i=0, Fibonacci pair (f0,f1)=(0,1), and moves to WRITE. start is ignored in WRITE, READ and DRAIN.
- WRITE: each cycle, we_a=1, addr_a=BASE_ADDR+i, data_a=f0; then (f0,f1)<=(f1,f0+f1), i<=i+1. After word COUNT-1, reload i=0, (f0,f1)=(0,1) and go to READ.
- READ: each cycle, addr_b=BASE_ADDR+i and expected value is advanced in step. From the second READ cycle onward, q_b is compared against the expected word of the previous address. After address COUNT-1, go to DRAIN.
- DRAIN: one cycle that compares the last word, then go to DONE.
- Compare: on the first mismatch, set err=1 and capture err_addr. Later mismatches leave err_addr unchanged.
- Arithmetic: Fibonacci sums wrap modulo 2^DATA_W. Addresses wrap modulo 2^ADDR_W, so BASE_ADDR+COUNT may exceed the top address.
- we_a=0 in every state except WRITE. we_b=0 and data_b=0 always.

## Timing
- Reset values: busy=0, done=0, err=0, err_addr=0, data_a=0, addr_a=0, we_a=0, addr_b=0; state IDLE.
- Reset mid-run: all outputs return to reset values immediately, including the asynchronous drop of we_a. No further writes occur.
- Edge E0 is the edge that samples start=1.
  - After E0: busy=1, and write word 0 is presented.
  - Word k is presented after edge E0+k.
  - Read address k is presented after edge E0+COUNT+k.
  - q_b for address k is compared at edge E0+COUNT+k+2.
- After edge E0+2·COUNT+1: busy=0 and done=1, with err and err_addr final. This is the same cycle that done rises.
- start held high in DONE begins a new run at the next edge. done drops in the cycle busy rises.

## Configuration
- FIB_BRAM_VERIFY_EN defined: full write, read-back and compare flow as above.
- FIB_BRAM_VERIFY_EN undefined: the READ and DRAIN states are removed, and WRITE goes directly to DONE.
  - busy=0 and done=1 after edge E0+COUNT.
  - addr_b, err and err_addr are held at 0.

## Test plan
- Default params, correct BRAM model, pulse start: 16 writes (0,1,1,2,3,5,8,13,21,34,55,89,144,233,377,610) at addresses 0..15; done=1 after edge E0+33; err=0.
- Corrupt the BRAM word at address 7 (13→14) before the read phase: err=1, err_addr=7, done after the same latency. Also corrupt address 9: err_addr stays 7.
- DATA_W=8, COUNT=16: F(13)=233 and F(14)=377 wraps to 121, F(15)=610 wraps to 98; no err.
- ADDR_W=4, BASE_ADDR=14, COUNT=4: writes go to addresses 14, 15, 0, 1; read-back passes.
- Assert reset at edge E0+5 mid-write: we_a=0 immediately and all outputs at reset values. A fresh start then completes a full run with err=0. Also hold start high during the run: no restart until DONE.
- Build without FIB_BRAM_VERIFY_EN: done after edge E0+16, addr_b=0, err=0 throughout.

Source files
------------

// File: rtl/fib_bram_seq_if.sv
// rtl/fib_bram_seq_if.sv - Control handshake and dual-port BRAM bus of the Fibonacci BRAM sequencer
//
// Purpose: bundles the start/busy/done handshake, the self-check result and
// both BRAM ports so the sequencer, its controller and the BRAM share one bus.
// Signals:
//   start            run request from the controller
//   busy, done       run in progress / run finished
//   err, err_addr    sticky mismatch flag and address of the first mismatch
//   data_a, addr_a, we_a   BRAM port A (write side)
//   data_b, addr_b, we_b   BRAM port B (read side, never written)
//   q_b              BRAM port B read data, one clock after addr_b
// Modports: master = sequencer, slave = controller/BRAM side.
interface fib_bram_seq_if #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 10
);
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] data_a;
  logic [ADDR_W-1:0] addr_a;
  logic              we_a;
  logic [DATA_W-1:0] data_b;
  logic [ADDR_W-1:0] addr_b;
  logic              we_b;
  logic [DATA_W-1:0] q_b;

  modport master (
    input  start, q_b,
    output busy, done, err, err_addr, data_a, addr_a, we_a, data_b, addr_b, we_b
  );

  modport slave (
    output start, q_b,
    input  busy, done, err, err_addr, data_a, addr_a, we_a, data_b, addr_b, we_b
  );
endinterface

// File: rtl/fib_bram_seq.sv
// rtl/fib_bram_seq.sv - Fills a dual-port BRAM with Fibonacci words and reads them back for checking
//
// Purpose: on start, writes COUNT Fibonacci words (wrapping modulo 2^DATA_W)
// through port A from BASE_ADDR upward (addresses wrap modulo 2^ADDR_W), then
// reads them back through port B and flags the first mismatching address.
// Optional feature macro: FIB_BRAM_VERIFY_EN. When undefined the read-back is
// left out, the run ends right after the last write, and addr_b/err/err_addr
// stay 0.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    fib_bram_seq_if master: handshake, result and both BRAM ports
// All bus outputs are registered.
module fib_bram_seq #(
  parameter int DATA_W    = 48,
  parameter int ADDR_W    = 10,
  parameter int COUNT     = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           reset,
  fib_bram_seq_if.master bus
);
  localparam int CNT_W = ADDR_W + 1;
  // Index value reached once the final word/address has been presented.
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(COUNT);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  i_q, i_d;
  logic [DATA_W-1:0] f0_q, f0_d, f1_q, f1_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, we_a_q, we_a_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d, addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [ADDR_W-1:0] cur_addr;
`ifdef FIB_BRAM_VERIFY_EN
  // Two-stage expected-value pipeline: stage 1 matches the address just put
  // on addr_b, stage 2 matches the word the BRAM is returning on q_b now.
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [DATA_W-1:0] e1_q, e1_d, e2_q, e2_d;
  logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
`endif

  assign cur_addr = BASE + i_q[ADDR_W-1:0];

  // The Fibonacci pair is kept one step ahead of the word being presented:
  // word 0 is emitted straight from the start branch, so (f0,f1) is loaded
  // with (F1,F2) and i with 1 at that point.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    f0_d       = f0_q;
    f1_d       = f1_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    data_a_d   = data_a_q;
    addr_a_d   = addr_a_q;
    we_a_d     = 1'b0;
    addr_b_d   = addr_b_q;
`ifdef FIB_BRAM_VERIFY_EN
    v1_d = 1'b0;
    e1_d = e1_q;
    a1_d = a1_q;
    v2_d = v1_q;
    e2_d = e1_q;
    a2_d = a1_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = WRITE;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_addr_d = '0;
          we_a_d     = 1'b1;
          addr_a_d   = BASE;
          data_a_d   = '0;
          i_d        = CNT_W'(1);
          f0_d       = DATA_W'(1);
          f1_d       = DATA_W'(1);
        end
      end
      WRITE: begin
        if (i_q == LAST) begin
`ifdef FIB_BRAM_VERIFY_EN
          state_d  = READ;
          addr_b_d = BASE;
          v1_d     = 1'b1;
          e1_d     = '0;
          a1_d     = BASE;
          i_d      = CNT_W'(1);
          f0_d     = DATA_W'(1);
          f1_d     = DATA_W'(1);
`else
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          we_a_d   = 1'b1;
          addr_a_d = cur_addr;
          data_a_d = f0_q;
          i_d      = i_q + CNT_W'(1);
          f0_d     = f1_q;
          f1_d     = f0_q + f1_q;
        end
      end
`ifdef FIB_BRAM_VERIFY_EN
      READ: begin
        if (i_q == LAST) begin
          state_d = DRAIN;
        end else begin
          addr_b_d = cur_addr;
          v1_d     = 1'b1;
          e1_d     = f0_q;
          a1_d     = cur_addr;
          i_d      = i_q + CNT_W'(1);
          f0_d     = f1_q;
          f1_d     = f0_q + f1_q;
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef FIB_BRAM_VERIFY_EN
    // Only the first mismatch of a run is recorded; err is sticky.
    if (v2_q && (bus.q_b != e2_q) && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = a2_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      f0_q       <= '0;
      f1_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      data_a_q   <= '0;
      addr_a_q   <= '0;
      we_a_q     <= 1'b0;
      addr_b_q   <= '0;
`ifdef FIB_BRAM_VERIFY_EN
      v1_q <= 1'b0;
      e1_q <= '0;
      a1_q <= '0;
      v2_q <= 1'b0;
      e2_q <= '0;
      a2_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      f0_q       <= f0_d;
      f1_q       <= f1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      data_a_q   <= data_a_d;
      addr_a_q   <= addr_a_d;
      we_a_q     <= we_a_d;
      addr_b_q   <= addr_b_d;
`ifdef FIB_BRAM_VERIFY_EN
      v1_q <= v1_d;
      e1_q <= e1_d;
      a1_q <= a1_d;
      v2_q <= v2_d;
      e2_q <= e2_d;
      a2_q <= a2_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
  assign bus.data_a   = data_a_q;
  assign bus.addr_a   = addr_a_q;
  assign bus.we_a     = we_a_q;
  assign bus.data_b   = '0;
  assign bus.addr_b   = addr_b_q;
  assign bus.we_b     = 1'b0;
endmodule

// File: tb/tb_fib_bram_seq.sv
// tb/tb_fib_bram_seq.sv - Self-checking bench for fib_bram_seq with two parameter sets and BRAM models
module tb_fib_bram_seq;
  localparam int D0 = 48, A0 = 10, C0 = 16, B0 = 0;
  localparam int D1 = 8,  A1 = 4,  C1 = 16, B1 = 14;
`ifdef FIB_BRAM_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct { int cyc; int addr; logic [63:0] data; } wr_t;
  typedef struct { int s; bit hold; int bad_a; int bad_b; bit exp_err; int exp_ea; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  int   sel;
  int   bad_a, bad_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  sb[$];
  logic [63:0] seen0[$];
  logic [63:0] seen1[$];
  vec_t vecs[7];

  fib_bram_seq_if #(.DATA_W(D0), .ADDR_W(A0)) bus0 ();
  fib_bram_seq_if #(.DATA_W(D1), .ADDR_W(A1)) bus1 ();

  fib_bram_seq #(.DATA_W(D0), .ADDR_W(A0), .COUNT(C0), .BASE_ADDR(B0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.master));
  fib_bram_seq #(.DATA_W(D1), .ADDR_W(A1), .COUNT(C1), .BASE_ADDR(B1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master));

  assign bus0.start = start && (sel == 0);
  assign bus1.start = start && (sel == 1);

  // BRAM models; a read of bad_a/bad_b returns the stored word plus one.
  logic [D0-1:0] mem0 [1<<A0];
  logic [D1-1:0] mem1 [1<<A1];
  always @(posedge clk) begin
    if (bus0.we_a) mem0[bus0.addr_a] <= bus0.data_a;
    bus0.q_b <= mem0[bus0.addr_b] + D0'((int'(bus0.addr_b) == bad_a) || (int'(bus0.addr_b) == bad_b));
    if (bus1.we_a) mem1[bus1.addr_a] <= bus1.data_a;
    bus1.q_b <= mem1[bus1.addr_b] + D1'((int'(bus1.addr_b) == bad_a) || (int'(bus1.addr_b) == bad_b));
  end

  logic        o_busy, o_done, o_err, o_we_a, o_we_b;
  logic [63:0] o_data_a, o_data_b;
  int          o_addr_a, o_addr_b, o_err_addr;
  always_comb begin
    if (sel == 0) begin
      o_busy = bus0.busy; o_done = bus0.done; o_err = bus0.err;
      o_we_a = bus0.we_a; o_we_b = bus0.we_b;
      o_data_a = 64'(bus0.data_a); o_data_b = 64'(bus0.data_b);
      o_addr_a = int'(bus0.addr_a); o_addr_b = int'(bus0.addr_b); o_err_addr = int'(bus0.err_addr);
    end else begin
      o_busy = bus1.busy; o_done = bus1.done; o_err = bus1.err;
      o_we_a = bus1.we_a; o_we_b = bus1.we_b;
      o_data_a = 64'(bus1.data_a); o_data_b = 64'(bus1.data_b);
      o_addr_a = int'(bus1.addr_a); o_addr_b = int'(bus1.addr_b); o_err_addr = int'(bus1.err_addr);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    int cnt, base, aw, lat, done_cyc, n_wr;
    logic [63:0] mask, f0, f1, t;
    bit side_bad;
    wr_t w;
    sel   = v.s;
    bad_a = v.bad_a;
    bad_b = v.bad_b;
    cnt   = (v.s == 0) ? C0 : C1;
    base  = (v.s == 0) ? B0 : B1;
    aw    = (v.s == 0) ? A0 : A1;
    mask  = (v.s == 0) ? 64'h0000_FFFF_FFFF_FFFF : 64'h0000_0000_0000_00FF;
    lat   = VERIFY ? 2 * cnt + 1 : cnt;
    if (v.s == 0) seen0.delete(); else seen1.delete();
    sb.delete();
    f0 = 0;
    f1 = 1;
    for (int j = 0; j < cnt; j++) begin
      sb.push_back('{j, (base + j) % (1 << aw), f0});
      t  = (f0 + f1) & mask;
      f0 = f1;
      f1 = t;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    n_wr     = 0;
    side_bad = 1'b0;
    for (int k = 0; k < 200 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (!v.hold) start = 1'b0;
      if (k == 0) begin
        check({tag, " busy_after_E0"}, 64'(o_busy), 64'd1);
        check({tag, " done_after_E0"}, 64'(o_done), 64'd0);
      end
      if (o_we_a) begin
        n_wr++;
        if (sb.size() != 0) begin
          w = sb.pop_front();
          check({tag, " wr_cycle"}, 64'(k), 64'(w.cyc));
          check({tag, " wr_addr"}, 64'(o_addr_a), 64'(w.addr));
          check({tag, " wr_data"}, o_data_a, w.data);
          if (v.s == 0) seen0.push_back(o_data_a); else seen1.push_back(o_data_a);
        end
      end
      if (o_we_b || o_data_b != 0 || (!VERIFY && (o_addr_b != 0 || o_err))) side_bad = 1'b1;
      if (o_done) done_cyc = k;
    end
    start = 1'b0;
    check({tag, " done_latency"}, 64'(done_cyc), 64'(lat));
    check({tag, " write_count"}, 64'(n_wr), 64'(cnt));
    check({tag, " busy_at_done"}, 64'(o_busy), 64'd0);
    check({tag, " err"}, 64'(o_err), 64'(v.exp_err & VERIFY));
    check({tag, " err_addr"}, 64'(o_err_addr), VERIFY ? 64'(v.exp_ea) : 64'd0);
    check({tag, " port_b_side"}, 64'(side_bad), 64'd0);
    sb.delete();
  endtask

  initial begin
    int n_we;
    vecs[0] = '{0, 1'b0, -1, -1, 1'b0, 0};
    vecs[1] = '{0, 1'b0,  7, -1, 1'b1, 7};
    vecs[2] = '{0, 1'b0,  7,  9, 1'b1, 7};
    vecs[3] = '{0, 1'b1, 15, -1, 1'b1, 15};
    vecs[4] = '{0, 1'b0,  0, -1, 1'b1, 0};
    vecs[5] = '{1, 1'b0, -1, -1, 1'b0, 0};
    vecs[6] = '{1, 1'b0,  0, 15, 1'b1, 15};

    reset = 1'b0;
    start = 1'b0;
    sel   = 0;
    bad_a = -1;
    bad_b = -1;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("rst busy", 64'(o_busy), 64'd0);
      check("rst done", 64'(o_done), 64'd0);
      check("rst err", 64'(o_err), 64'd0);
      check("rst err_addr", 64'(o_err_addr), 64'd0);
      check("rst we_a", 64'(o_we_a), 64'd0);
      check("rst addr_a", 64'(o_addr_a), 64'd0);
      check("rst data_a", o_data_a, 64'd0);
      check("rst addr_b", 64'(o_addr_b), 64'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("row%0d", i));

    // Reset in the middle of the write phase.
    sel   = 0;
    bad_a = -1;
    bad_b = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid we_a", 64'(o_we_a), 64'd1);
    check("mid addr_a", 64'(o_addr_a), 64'd5);
    check("mid data_a", o_data_a, 64'd5);
    reset = 1'b0;
    #1;
    check("arst we_a", 64'(o_we_a), 64'd0);
    check("arst busy", 64'(o_busy), 64'd0);
    check("arst done", 64'(o_done), 64'd0);
    check("arst addr_a", 64'(o_addr_a), 64'd0);
    check("arst data_a", o_data_a, 64'd0);
    check("arst err", 64'(o_err), 64'd0);
    n_we = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_we_a) n_we++;
    end
    check("arst no_writes", 64'(n_we), 64'd0);
    reset = 1'b1;
    run(vecs[0], "post_reset");

    check("seen0 size", 64'(seen0.size()), 64'd16);
    if (seen0.size() == 16) begin
      check("F7 default", seen0[7], 64'd13);
      check("F15 default", seen0[15], 64'd610);
    end
    check("seen1 size", 64'(seen1.size()), 64'd16);
    if (seen1.size() == 16) begin
      check("F13 8bit", seen1[13], 64'd233);
      check("F14 8bit wrap", seen1[14], 64'd121);
      check("F15 8bit wrap", seen1[15], 64'd98);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
